rst_sequencer: RTL

Reset generator that drives the active-low asynchronous resets consumed by the design's flip-flops. The reset pin is synchronised with assert-async / deassert-sync behaviour, release waits for a stable PLL lock, and downstream domains come out of reset in a fixed staged order. It also re-sequences on PLL lock loss and on a software request. It sits at the top level, between the board reset pin / PLL and every block's `reset` input.

---
 rtl/rst_sequencer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/rst_sequencer.sv
// Reset sequencer: pin reset synchronised with async assert / sync deassert, PLL lock qualification,
// a hold period, then staged release of NUM_STAGES active-low resets. Re-sequences on lock loss or soft request.
module rst_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_STABLE = 8,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 4,
    parameter int NUM_STAGES  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  lock,
    input  logic                  sw_rst_req,
    output logic [NUM_STAGES-1:0] rst_n_o,
    output logic                  rst_done,
    output logic [1:0]            rst_cause
);

    localparam int REL_SPAN = (NUM_STAGES - 1) * STAGE_GAP + 1;
    localparam int MAX_LH   = (LOCK_STABLE > HOLD_CYCLES) ? LOCK_STABLE : HOLD_CYCLES;
    localparam int CNT_MAX  = (MAX_LH > REL_SPAN) ? MAX_LH : REL_SPAN;
    localparam int CW       = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_STABLE - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REL_LAST  = CW'((NUM_STAGES - 1) * STAGE_GAP - 1);

    localparam logic [1:0] CAUSE_PIN  = 2'b00;
    localparam logic [1:0] CAUSE_LOCK = 2'b01;
    localparam logic [1:0] CAUSE_SW   = 2'b10;

    typedef enum logic [2:0] {
        ST_ASSERT,
        ST_WAIT_LOCK,
        ST_HOLD,
        ST_RELEASE,
        ST_RUN
    } state_t;

    state_t                  r_state;
    logic [CW-1:0]           r_cnt;
    logic [NUM_STAGES-1:0]   r_rst_n;
    logic                    r_done;
    logic [1:0]              r_cause;
    logic [SYNC_STAGES-1:0]  r_rst_sync;
    logic [SYNC_STAGES-1:0]  r_lock_sync;
    logic                    w_rstn_s;
    logic                    w_lock_s;
    logic [NUM_STAGES-1:0]   w_stage_hit;

    // Both chains clear asynchronously so a pin reset also forgets any stale lock history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rst_sync  <= '0;
            r_lock_sync <= '0;
        end else begin
            r_rst_sync  <= {r_rst_sync[SYNC_STAGES-2:0], 1'b1};
            r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], lock};
        end
    end

    assign w_rstn_s = r_rst_sync[SYNC_STAGES-1];
    assign w_lock_s = r_lock_sync[SYNC_STAGES-1];

    // Stage i releases i*STAGE_GAP edges after RELEASE entry, i.e. when the counter reads i*STAGE_GAP-1.
    always_comb begin
        w_stage_hit = '0;
        for (int i = 1; i < NUM_STAGES; i++)
            w_stage_hit[i] = (r_cnt == CW'(i * STAGE_GAP - 1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_ASSERT;
            r_cnt   <= '0;
            r_rst_n <= '0;
            r_done  <= 1'b0;
            r_cause <= CAUSE_PIN;
        end else begin
            case (r_state)
                ST_ASSERT: begin
                    if (w_rstn_s) begin
                        r_state <= ST_WAIT_LOCK;
                        r_cnt   <= '0;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (!w_lock_s)
                        r_cnt <= '0;
                    else if (r_cnt == LOCK_LAST) begin
                        r_state <= ST_HOLD;
                        r_cnt   <= '0;
                    end else
                        r_cnt <= r_cnt + CW'(1);
                end
                ST_HOLD: begin
                    if (!w_lock_s) begin
                        r_state <= ST_WAIT_LOCK;
                        r_cnt   <= '0;
                        r_rst_n <= '0;
                        r_done  <= 1'b0;
                        r_cause <= CAUSE_LOCK;
                    end else if (r_cnt == HOLD_LAST) begin
                        r_cnt      <= '0;
                        r_rst_n[0] <= 1'b1;
                        if (NUM_STAGES == 1) begin
                            r_state <= ST_RUN;
                            r_done  <= 1'b1;
                        end else
                            r_state <= ST_RELEASE;
                    end else
                        r_cnt <= r_cnt + CW'(1);
                end
                ST_RELEASE: begin
                    if (!w_lock_s) begin
                        r_state <= ST_WAIT_LOCK;
                        r_cnt   <= '0;
                        r_rst_n <= '0;
                        r_done  <= 1'b0;
                        r_cause <= CAUSE_LOCK;
                    end else begin
                        r_rst_n <= r_rst_n | w_stage_hit;
                        if (r_cnt == REL_LAST) begin
                            r_state <= ST_RUN;
                            r_done  <= 1'b1;
                            r_cnt   <= '0;
                        end else
                            r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_RUN: begin
                    // Lock loss outranks a coincident soft request.
                    if (!w_lock_s) begin
                        r_state <= ST_WAIT_LOCK;
                        r_cnt   <= '0;
                        r_rst_n <= '0;
                        r_done  <= 1'b0;
                        r_cause <= CAUSE_LOCK;
                    end else if (sw_rst_req) begin
                        r_state <= ST_HOLD;
                        r_cnt   <= '0;
                        r_rst_n <= '0;
                        r_done  <= 1'b0;
                        r_cause <= CAUSE_SW;
                    end
                end
                default: begin
                    r_state <= ST_ASSERT;
                    r_cnt   <= '0;
                    r_rst_n <= '0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign rst_n_o   = r_rst_n;
    assign rst_done  = r_done;
    assign rst_cause = r_cause;

endmodule
